sr_latch_sequencer: RTL and testbench

SR_LATCH_SEQUENCER -- requirements
Module: sr_latch_sequencer

---
 rtl/sr_latch_sequencer.sv | 177 +++++++++++++++++
 tb/tb_sr_latch_sequencer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_latch_sequencer.sv
// sr_latch_sequencer
//   Sequences set/reset operations onto a bank of N gated SR latches on
//   behalf of two requesters (A and B). A grant is followed by a fixed-length
//   drive: one SETUP cycle with s/r applied, PULSE_CYCLES cycles with the
//   target enable high, then GUARD_CYCLES cycles of s/r hold with the enable
//   low. A shadow copy of the latch contents is kept in state_q.
//
// Ports
//   clk            rising-edge clock
//   rst_n          synchronous active-low reset
//   req_a/req_b    operation requests, held until acknowledged
//   op_a/op_b      1 = set, 0 = reset
//   idx_a/idx_b    target latch index
//   ack_a/ack_b    one-cycle grant pulses
//   s, r, en       per-latch set, reset and enable drives
//   busy           high while an operation is in SETUP/PULSE/HOLD
//   done           one-cycle completion pulse (first IDLE cycle)
//   err            one-cycle pulse when a grant carried an out-of-range index
//   state_q        expected latch contents
module sr_latch_sequencer #(
    parameter int N            = 4,
    parameter int IDXW         = 2,
    parameter int PULSE_CYCLES = 2,
    parameter int GUARD_CYCLES = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_a,
    input  logic            req_b,
    input  logic            op_a,
    input  logic            op_b,
    input  logic [IDXW-1:0] idx_a,
    input  logic [IDXW-1:0] idx_b,
    output logic            ack_a,
    output logic            ack_b,
    output logic [N-1:0]    s,
    output logic [N-1:0]    r,
    output logic [N-1:0]    en,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [N-1:0]    state_q
);

    // The phase counter counts down from (length - 1) to 0, so it only has
    // to hold values up to max(PULSE_CYCLES, GUARD_CYCLES) - 1.
    localparam int MAXC = (PULSE_CYCLES > GUARD_CYCLES) ? PULSE_CYCLES : GUARD_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [CW-1:0]   PULSE_LD = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0]   GUARD_LD = CW'(GUARD_CYCLES - 1);
    localparam logic [IDXW:0]   N_LIM    = (IDXW + 1)'(N);
    localparam logic [N-1:0]    ONE      = {{(N - 1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        PULSE = 2'd2,
        HOLD  = 2'd3
    } fsm_t;

    fsm_t            fsm_q;
    logic [CW-1:0]   cnt_q;
    logic            last_b_q;   // 1 when B was the most recent grantee
    logic            ack_a_q;
    logic            ack_b_q;
    logic [N-1:0]    s_q;
    logic [N-1:0]    r_q;
    logic [N-1:0]    en_q;
    logic            busy_q;
    logic            done_q;
    logic            err_q;
    logic [N-1:0]    latch_q;

    // Grant decision, only consumed while IDLE.
    logic            pick_a_d;
    logic            pick_b_d;
    logic            sel_op_d;
    logic [IDXW-1:0] sel_idx_d;
    logic            sel_bad_d;
    logic [N-1:0]    sel_mask_d;

    always_comb begin
        // On a tie the requester that was not served last wins.
        pick_a_d   = req_a & (~req_b | last_b_q);
        pick_b_d   = req_b & ~pick_a_d;
        sel_op_d   = pick_a_d ? op_a : op_b;
        sel_idx_d  = pick_a_d ? idx_a : idx_b;
        sel_bad_d  = ({1'b0, sel_idx_d} >= N_LIM);
        sel_mask_d = ONE << sel_idx_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q    <= IDLE;
            cnt_q    <= '0;
            last_b_q <= 1'b1;
            ack_a_q  <= 1'b0;
            ack_b_q  <= 1'b0;
            s_q      <= '0;
            r_q      <= '0;
            en_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            latch_q  <= '0;
        end else begin
            ack_a_q <= 1'b0;
            ack_b_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;

            case (fsm_q)
                IDLE: begin
                    if (pick_a_d || pick_b_d) begin
                        ack_a_q  <= pick_a_d;
                        ack_b_q  <= pick_b_d;
                        last_b_q <= pick_b_d;
                        if (sel_bad_d) begin
                            // Rejected grant: acknowledge and flag, but drive nothing.
                            err_q <= 1'b1;
                        end else begin
                            fsm_q  <= SETUP;
                            busy_q <= 1'b1;
                            s_q    <= sel_op_d ? sel_mask_d : '0;
                            r_q    <= sel_op_d ? '0 : sel_mask_d;
                        end
                    end
                end

                SETUP: begin
                    fsm_q <= PULSE;
                    cnt_q <= PULSE_LD;
                    // Exactly one of s_q/r_q carries the target bit.
                    en_q  <= s_q | r_q;
                end

                PULSE: begin
                    if (cnt_q == '0) begin
                        fsm_q   <= HOLD;
                        cnt_q   <= GUARD_LD;
                        en_q    <= '0;
                        // Target bit takes the set value, others are untouched.
                        latch_q <= (latch_q & ~(s_q | r_q)) | s_q;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end

                HOLD: begin
                    if (cnt_q == '0) begin
                        fsm_q  <= IDLE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        s_q    <= '0;
                        r_q    <= '0;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end

                default: fsm_q <= IDLE;
            endcase
        end
    end

    assign ack_a   = ack_a_q;
    assign ack_b   = ack_b_q;
    assign s       = s_q;
    assign r       = r_q;
    assign en      = en_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;
    assign state_q = latch_q;

endmodule

// File: tb/tb_sr_latch_sequencer.sv
module tb_sr_latch_sequencer;

    localparam int N    = 4;
    localparam int IDXW = 2;
    localparam int P    = 2;
    localparam int G    = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance (N=4)
    logic            rst_n = 1'b0;
    logic            req_a = 1'b0, req_b = 1'b0, op_a = 1'b0, op_b = 1'b0;
    logic [IDXW-1:0] idx_a = '0, idx_b = '0;
    logic            ack_a, ack_b, busy, done, err;
    logic [N-1:0]    s, r, en, state_q;

    // Second instance (N=3) for out-of-range index checks
    logic            req_a3 = 1'b0, req_b3 = 1'b0, op_a3 = 1'b0, op_b3 = 1'b0;
    logic [1:0]      idx_a3 = '0, idx_b3 = '0;
    logic            ack_a3, ack_b3, busy3, done3, err3;
    logic [2:0]      s3, r3, en3, state_q3;

    sr_latch_sequencer #(.N(N), .IDXW(IDXW), .PULSE_CYCLES(P), .GUARD_CYCLES(G)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_a(req_a), .req_b(req_b), .op_a(op_a), .op_b(op_b),
        .idx_a(idx_a), .idx_b(idx_b),
        .ack_a(ack_a), .ack_b(ack_b),
        .s(s), .r(r), .en(en),
        .busy(busy), .done(done), .err(err), .state_q(state_q)
    );

    sr_latch_sequencer #(.N(3), .IDXW(2), .PULSE_CYCLES(P), .GUARD_CYCLES(G)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_a(req_a3), .req_b(req_b3), .op_a(op_a3), .op_b(op_b3),
        .idx_a(idx_a3), .idx_b(idx_b3),
        .ack_a(ack_a3), .ack_b(ack_b3),
        .s(s3), .r(r3), .en(en3),
        .busy(busy3), .done(done3), .err(err3), .state_q(state_q3)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: tracks the cycle offset since the grant edge and
    // derives every output from that offset.
    // ------------------------------------------------------------------
    int           m_phase = 0;    // 0 = idle, k = k-th cycle after grant edge
    int           m_idx   = 0;
    logic         m_op    = 1'b0;
    logic         m_lastb = 1'b1;
    logic [N-1:0] m_latch = '0;
    logic         m_ack_a = 1'b0, m_ack_b = 1'b0, m_done = 1'b0, m_err = 1'b0;

    task automatic model_edge();
        int   gi;
        int   idx;
        logic op;
        if (!rst_n) begin
            m_phase = 0; m_latch = '0; m_lastb = 1'b1;
            m_ack_a = 1'b0; m_ack_b = 1'b0; m_done = 1'b0; m_err = 1'b0;
        end else begin
            m_ack_a = 1'b0; m_ack_b = 1'b0; m_done = 1'b0; m_err = 1'b0;
            if (m_phase == 0) begin
                gi = -1;
                if (req_a && req_b) gi = m_lastb ? 0 : 1;
                else if (req_a)     gi = 0;
                else if (req_b)     gi = 1;
                if (gi >= 0) begin
                    m_lastb = (gi == 1);
                    if (gi == 0) m_ack_a = 1'b1; else m_ack_b = 1'b1;
                    op  = (gi == 0) ? op_a : op_b;
                    idx = (gi == 0) ? int'(idx_a) : int'(idx_b);
                    if (idx >= N) m_err = 1'b1;
                    else begin
                        m_phase = 1; m_op = op; m_idx = idx;
                    end
                end
            end else begin
                m_phase++;
                if (m_phase == P + 2) m_latch[m_idx] = m_op;
                if (m_phase == P + G + 2) begin
                    m_phase = 0;
                    m_done  = 1'b1;
                end
            end
        end
    endtask

    function automatic logic [20:0] model_out();
        logic [N-1:0] one, tgt, es, er, een;
        one = 1;
        tgt = (m_phase != 0) ? (one << m_idx) : '0;
        es  = m_op ? tgt : '0;
        er  = m_op ? '0 : tgt;
        een = (m_phase >= 2 && m_phase <= P + 1) ? tgt : '0;
        return {m_ack_a, m_ack_b, (m_phase != 0), m_done, m_err, es, er, een, m_latch};
    endfunction

    function automatic logic [20:0] dut_out();
        return {ack_a, ack_b, busy, done, err, s, r, en, state_q};
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_a = 1'b0; req_b = 1'b0; req_a3 = 1'b0; req_b3 = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic wait_done(input string name);
        int k;
        k = -1;
        for (int i = 1; i <= 12; i++) begin
            step();
            chk({name, "_s_r_overlap"}, 32'(s & r), 32'd0);
            if (done) begin
                k = i;
                break;
            end
        end
        chk({name, "_done_latency"}, 32'(k), 32'(P + G + 1));
    endtask

    // ------------------------------------------------------------------
    // Directed vector table
    // ------------------------------------------------------------------
    typedef struct {
        logic       rst;
        logic       ra, oa;
        logic [1:0] ia;
        logic       rb, ob;
        logic [1:0] ib;
        logic [20:0] exp;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic ra, input logic oa, input logic [1:0] ia,
                                input logic rb, input logic ob, input logic [1:0] ib,
                                input logic eaa, input logic eab, input logic ebusy,
                                input logic edone, input logic eerr,
                                input logic [3:0] es, input logic [3:0] er,
                                input logic [3:0] een, input logic [3:0] esq);
        vec_t v;
        v.rst = rst; v.ra = ra; v.oa = oa; v.ia = ia;
        v.rb = rb; v.ob = ob; v.ib = ib;
        v.exp = {eaa, eab, ebusy, edone, eerr, es, er, een, esq};
        return v;
    endfunction

    initial begin
        vec_t tbl[$];
        int   order[$];
        int   granted;
        int   cyc;

        //            rst ra oa ia  rb ob ib   ackA ackB busy done err  s       r       en      state_q
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000)); // reset
        tbl.push_back(mk(1, 1, 1, 2, 0, 0, 0,  1, 0, 1, 0, 0, 4'b0100, 4'b0000, 4'b0000, 4'b0000)); // set 2: SETUP
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 4'b0100, 4'b0000, 4'b0100, 4'b0000)); // PULSE 1
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 4'b0100, 4'b0000, 4'b0100, 4'b0000)); // PULSE 2
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 4'b0100, 4'b0000, 4'b0000, 4'b0100)); // HOLD
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0100)); // done
        tbl.push_back(mk(1, 0, 0, 0, 1, 0, 2,  0, 1, 1, 0, 0, 4'b0000, 4'b0100, 4'b0000, 4'b0100)); // back-to-back reset 2
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 3,  0, 0, 1, 0, 0, 4'b0000, 4'b0100, 4'b0100, 4'b0100)); // op/idx change ignored
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 4'b0000, 4'b0100, 4'b0100, 4'b0100));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 4'b0000, 4'b0100, 4'b0000, 4'b0000));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
        tbl.push_back(mk(1, 1, 1, 1, 0, 0, 0,  1, 0, 1, 0, 0, 4'b0010, 4'b0000, 4'b0000, 4'b0000)); // set 1
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 4'b0010, 4'b0000, 4'b0010, 4'b0000));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 4'b0010, 4'b0000, 4'b0010, 4'b0000));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000)); // reset mid-pulse
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000)); // no done
        tbl.push_back(mk(1, 1, 1, 3, 0, 0, 0,  1, 0, 1, 0, 0, 4'b1000, 4'b0000, 4'b0000, 4'b0000)); // top index
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 4'b1000, 4'b0000, 4'b1000, 4'b0000));

        foreach (tbl[i]) begin
            rst_n = tbl[i].rst;
            req_a = tbl[i].ra; op_a = tbl[i].oa; idx_a = tbl[i].ia;
            req_b = tbl[i].rb; op_b = tbl[i].ob; idx_b = tbl[i].ib;
            step();
            chk($sformatf("vec[%0d]", i), 32'(dut_out()), 32'(tbl[i].exp));
        end

        // Tie after reset: A wins, B served straight out of A's done cycle.
        do_reset();
        req_a = 1'b1; op_a = 1'b1; idx_a = 2'd0;
        req_b = 1'b1; op_b = 1'b0; idx_b = 2'd0;
        step();
        chk("tie_first_ack", 32'({ack_a, ack_b}), 32'b10);
        req_a = 1'b0;
        wait_done("tie_a");
        chk("tie_a_state", 32'(state_q), 32'b0001);
        step();
        chk("tie_second_ack", 32'({ack_a, ack_b}), 32'b01);
        req_b = 1'b0;
        wait_done("tie_b");
        chk("tie_final_state", 32'(state_q), 32'b0000);

        // Round-robin with both requesters held high.
        do_reset();
        req_a = 1'b1; op_a = 1'b1; idx_a = 2'd1;
        req_b = 1'b1; op_b = 1'b1; idx_b = 2'd2;
        for (int i = 0; i < 40 && order.size() < 4; i++) begin
            step();
            chk("rr_s_r_overlap", 32'(s & r), 32'd0);
            if (ack_a) order.push_back(0);
            if (ack_b) order.push_back(1);
        end
        for (int i = 0; i < 4; i++)
            chk($sformatf("rr_ack[%0d]", i), (i < order.size()) ? 32'(order[i]) : 32'hDEAD, 32'(i % 2));
        req_a = 1'b0; req_b = 1'b0;

        // Out-of-range index on the N=3 instance.
        do_reset();
        req_b3 = 1'b1; op_b3 = 1'b1; idx_b3 = 2'd3;
        step();
        chk("bad_b_ack_err", 32'({ack_a3, ack_b3, err3}), 32'b011);
        chk("bad_b_busy_en", 32'({busy3, en3, s3, r3}), 32'd0);
        req_b3 = 1'b0;
        req_a3 = 1'b1; op_a3 = 1'b1; idx_a3 = 2'd3;
        step();
        chk("bad_a_ack_err", 32'({ack_a3, ack_b3, err3}), 32'b101);
        chk("bad_a_busy_en", 32'({busy3, en3, s3, r3, state_q3}), 32'd0);
        // Pointer moved to A on the rejected grant, so B must win this tie.
        req_a3 = 1'b1; op_a3 = 1'b1; idx_a3 = 2'd1;
        req_b3 = 1'b1; op_b3 = 1'b1; idx_b3 = 2'd0;
        step();
        chk("bad_rr_ack", 32'({ack_a3, ack_b3, err3, busy3}), 32'b0101);
        req_a3 = 1'b0; req_b3 = 1'b0;
        begin
            int k;
            k = -1;
            for (int i = 1; i <= 12; i++) begin
                step();
                if (done3) begin
                    k = i;
                    break;
                end
            end
            chk("n3_done_latency", 32'(k), 32'(P + G + 1));
            chk("n3_state", 32'(state_q3), 32'b001);
        end

        // Randomized requests against the reference model.
        do_reset();
        granted = 0;
        cyc     = 0;
        while (granted < 1000 && cyc < 20000) begin
            step();
            cyc++;
            chk("model", 32'(dut_out()), 32'(model_out()));
            chk("rand_s_r_overlap", 32'(s & r), 32'd0);
            chk("rand_en_onehot", 32'($countones(en) <= 1), 32'd1);

            rst_n = ($urandom_range(299) == 0) ? 1'b0 : 1'b1;
            if (ack_a) begin
                granted++;
                op_a  = 1'($urandom);
                idx_a = 2'($urandom);
                if ($urandom_range(1) == 0) req_a = 1'b0;
            end else if (!req_a) begin
                op_a  = 1'($urandom);
                idx_a = 2'($urandom);
                if ($urandom_range(2) == 0) req_a = 1'b1;
            end
            if (ack_b) begin
                granted++;
                op_b  = 1'($urandom);
                idx_b = 2'($urandom);
                if ($urandom_range(1) == 0) req_b = 1'b0;
            end else if (!req_b) begin
                op_b  = 1'($urandom);
                idx_b = 2'($urandom);
                if ($urandom_range(2) == 0) req_b = 1'b1;
            end
        end
        chk("rand_grants", 32'(granted), 32'd1000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
